// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port memory arbiter.
package mem_arb_pkg;

    localparam int unsigned ADDR_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } arb_state_t;

    typedef enum logic {
        OWN_IF,
        OWN_D
    } owner_t;

    // Latched request header for the single outstanding transaction.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              we;
        owner_t            owner;
    } txn_hdr_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of requester (IF/D) and memory-side signals around mem_arbiter.
interface mem_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int unsigned N = 32
) ();

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_rvalid;
    logic [N-1:0]      if_rdata;
    logic              if_stall;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [N-1:0]      d_wdata;
    logic              d_rvalid;
    logic [N-1:0]      d_rdata;
    logic              d_stall;

    logic              proc_req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [N-1:0]      wdata;
    logic              mem_ready;
    logic              valid;
    logic [N-1:0]      rdata;

    // Arbiter view
    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_ready, valid, rdata,
        output if_rvalid, if_rdata, if_stall, d_rvalid, d_rdata, d_stall,
               proc_req, we, addr, wdata
    );

    // Environment view: requesters plus memory
    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_ready, valid, rdata,
        input  if_rvalid, if_rdata, if_stall, d_rvalid, d_rdata, d_stall,
               proc_req, we, addr, wdata
    );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between IF and D requesters.
// ARB_RR_EN defined: ties go to the port not served last; otherwise D always wins ties.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic   if_req,
    input  logic   d_req,
    input  owner_t last_served,
    output owner_t winner_c
);

`ifdef ARB_RR_EN
    always_comb begin
        winner_c = OWN_D;
        if (if_req && d_req) begin
            winner_c = (last_served == OWN_D) ? OWN_IF : OWN_D;
        end else if (if_req) begin
            winner_c = OWN_IF;
        end
    end
`else
    logic unused_last_served;
    assign unused_last_served = (last_served == OWN_IF);

    always_comb begin
        winner_c = OWN_D;
        if (if_req && !d_req) begin
            winner_c = OWN_IF;
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data) arbiter onto a single-outstanding memory bus.
// Tie policy selected by ARB_RR_EN (see mem_arb_pick); default build gives D priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);

    arb_state_t   state_q, state_n;
    txn_hdr_t     hdr_q, hdr_n;
    logic [N-1:0] wdata_q, wdata_n;
    owner_t       last_q, last_n;
    logic         proc_req_q;
    owner_t       pick_c;
    logic         done_c;

    mem_arb_pick u_pick (
        .if_req      (bus.if_req),
        .d_req       (bus.d_req),
        .last_served (last_q),
        .winner_c    (pick_c)
    );

    // State and latched transaction registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            hdr_q      <= '{addr: '0, we: 1'b0, owner: OWN_D};
            wdata_q    <= '0;
            last_q     <= OWN_D;
            proc_req_q <= 1'b0;
        end else begin
            state_q    <= state_n;
            hdr_q      <= hdr_n;
            wdata_q    <= wdata_n;
            last_q     <= last_n;
            proc_req_q <= (state_n == ISSUE);
        end
    end

    // Next state, latch capture and completion detect
    always_comb begin
        state_n = state_q;
        hdr_n   = hdr_q;
        wdata_n = wdata_q;
        last_n  = last_q;
        done_c  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.if_req || bus.d_req) begin
                    state_n     = ISSUE;
                    hdr_n.owner = pick_c;
                    if (pick_c == OWN_IF) begin
                        hdr_n.addr = bus.if_addr;
                        hdr_n.we   = 1'b0;
                        wdata_n    = '0;
                    end else begin
                        hdr_n.addr = bus.d_addr;
                        hdr_n.we   = bus.d_we;
                        wdata_n    = bus.d_wdata;
                    end
                end
            end
            ISSUE: begin
                if (bus.mem_ready) begin
                    if (bus.valid) begin
                        done_c  = 1'b1;
                        state_n = IDLE;
                    end else begin
                        state_n = WAIT;
                    end
                end
            end
            WAIT: begin
                if (bus.valid) begin
                    done_c  = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        if (done_c) begin
            last_n = hdr_q.owner;
        end
    end

    // Memory side is driven purely from the latched transaction
    assign bus.proc_req = proc_req_q;
    assign bus.we       = hdr_q.we;
    assign bus.addr     = hdr_q.addr;
    assign bus.wdata    = wdata_q;

    // Completion is steered to the owner in the same cycle the response arrives
    assign bus.if_rvalid = done_c && (hdr_q.owner == OWN_IF);
    assign bus.d_rvalid  = done_c && (hdr_q.owner == OWN_D);
    assign bus.if_rdata  = bus.rdata;
    assign bus.d_rdata   = bus.rdata;
    assign bus.if_stall  = bus.if_req && !bus.if_rvalid;
    assign bus.d_stall   = bus.d_req && !bus.d_rvalid;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed latency/reset/tie cases plus randomized traffic.
module tb_mem_arbiter;

    localparam int unsigned N = 32;

    logic clk;
    logic rst;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    mem_arbiter_if #(.N(N)) bus ();

    mem_arbiter #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0]  addr;
        logic         we;
        logic [N-1:0] wdata;
        logic [N-1:0] rdata;
        int           lat;
        int           t0;
    } exp_t;

    typedef struct {
        logic [31:0]  addr;
        logic         we;
        logic [N-1:0] wdata;
    } acc_t;

    typedef struct {
        int           cyc;
        logic [31:0]  addr;
        logic         we;
        logic [N-1:0] wdata;
    } beat_t;

    exp_t  if_q[$];
    exp_t  d_q[$];
    acc_t  acc_q[$];
    beat_t iss_log[$];
    int    dstall_log[$];
    bit    grant_log[$];

    logic [N-1:0] ref_mem [bit [31:0]];
    logic [N-1:0] mem_arr [bit [31:0]];

    bit plan_rand = 1'b0;
    int plan_rdly = 0;
    int plan_vdly = 0;
    bit inj_valid = 1'b0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    function automatic void fail(input string name, input string act, input string req);
        total++;
        bad++;
        $display("FAIL %s: got %s want %s (cycle %0d)", name, act, req, cyc);
    endfunction

    function automatic logic [N-1:0] dflt(input logic [31:0] a);
        return N'(a ^ 32'h5A5A_0F0F);
    endfunction

    function automatic void preload(input logic [31:0] a, input logic [N-1:0] d);
        ref_mem[a] = d;
        mem_arr[a] = d;
    endfunction

    // Reference: per-port program order; reads see the latest write, writes echo ~wdata
    function automatic void push_exp(input bit is_d, input logic [31:0] a, input logic w,
                                     input logic [N-1:0] wd, input int lat);
        exp_t e;
        e.addr  = a;
        e.we    = is_d ? w : 1'b0;
        e.wdata = is_d ? wd : '0;
        if (e.we) begin
            ref_mem[a] = wd;
            e.rdata    = ~wd;
        end else begin
            e.rdata = ref_mem.exists(a) ? ref_mem[a] : dflt(a);
        end
        e.lat = lat;
        e.t0  = cyc;
        if (is_d) d_q.push_back(e);
        else      if_q.push_back(e);
    endfunction

    function automatic void complete(input bit is_d);
        exp_t e;
        acc_t a;
        grant_log.push_back(is_d);
        if (is_d && d_q.size() == 0) begin
            fail("d_rvalid_unexpected", "pulse", "none");
            return;
        end
        if (!is_d && if_q.size() == 0) begin
            fail("if_rvalid_unexpected", "pulse", "none");
            return;
        end
        if (is_d) e = d_q.pop_front();
        else      e = if_q.pop_front();
        chk(is_d ? "d_rdata" : "if_rdata", is_d ? bus.d_rdata : bus.if_rdata, e.rdata);
        chk("other_port_rdata", is_d ? bus.if_rdata : bus.d_rdata, e.rdata);
        if (e.lat >= 0) chk("latency", cyc - e.t0, e.lat);
        if (acc_q.size() == 0) begin
            fail("mem_accept", "none", "one accepted request");
        end else begin
            a = acc_q.pop_front();
            chk("bus_addr", a.addr, e.addr);
            chk("bus_we", a.we, e.we);
            chk("bus_wdata", a.wdata, e.wdata);
        end
    endfunction

    // Monitor: samples mid-cycle, pops the scoreboard on every completion
    always @(negedge clk) begin
        chk("if_stall", bus.if_stall, bus.if_req && !bus.if_rvalid);
        chk("d_stall", bus.d_stall, bus.d_req && !bus.d_rvalid);
        if (bus.if_rvalid && bus.d_rvalid) fail("dual_rvalid", "both", "at most one");
        if (bus.if_rvalid) complete(1'b0);
        if (bus.d_rvalid)  complete(1'b1);
        if (bus.proc_req) iss_log.push_back('{cyc, bus.addr, bus.we, bus.wdata});
        if (bus.d_stall)  dstall_log.push_back(cyc);
    end

    // Memory device: programmable ready delay, then valid delay (0 = same cycle as ready)
    initial begin
        int m_phase, m_cnt, m_vdly;
        logic [N-1:0] m_resp;
        acc_t acc;
        m_phase = 0;
        m_cnt   = 0;
        m_vdly  = 0;
        m_resp  = '0;
        bus.mem_ready = 1'b0;
        bus.valid     = 1'b0;
        bus.rdata     = '0;
        forever begin
            @(posedge clk);
            #2;
            bus.mem_ready = 1'b0;
            bus.valid     = 1'b0;
            if (rst) begin
                m_phase = 0;
            end else begin
                if (m_phase == 0 && bus.proc_req) begin
                    m_cnt   = plan_rand ? int'($urandom_range(0, 3)) : plan_rdly;
                    m_vdly  = plan_rand ? int'($urandom_range(0, 3)) : plan_vdly;
                    m_phase = 1;
                end
                if (m_phase == 1) begin
                    if (m_cnt == 0) begin
                        acc.addr  = bus.addr;
                        acc.we    = bus.we;
                        acc.wdata = bus.wdata;
                        acc_q.push_back(acc);
                        if (bus.we) begin
                            mem_arr[bus.addr] = bus.wdata;
                            m_resp = ~bus.wdata;
                        end else begin
                            m_resp = mem_arr.exists(bus.addr) ? mem_arr[bus.addr] : dflt(bus.addr);
                        end
                        bus.mem_ready = 1'b1;
                        if (m_vdly == 0) begin
                            bus.valid = 1'b1;
                            bus.rdata = m_resp;
                            m_phase   = 0;
                        end else begin
                            m_cnt   = m_vdly;
                            m_phase = 2;
                        end
                    end else begin
                        m_cnt--;
                    end
                end else if (m_phase == 2) begin
                    m_cnt--;
                    if (m_cnt == 0) begin
                        bus.valid = 1'b1;
                        bus.rdata = m_resp;
                        m_phase   = 0;
                    end
                end
                if (inj_valid) begin
                    bus.valid = 1'b1;
                    bus.rdata = 32'hBAD0_BAD0;
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rv(input bit is_d);
        int n;
        bit done;
        n    = 0;
        done = 1'b0;
        while (!done) begin
            @(negedge clk);
            done = is_d ? bus.d_rvalid : bus.if_rvalid;
            n++;
            if (!done && n >= 300) begin
                fail(is_d ? "d_rvalid_timeout" : "if_rvalid_timeout", "no pulse", "pulse within 300 cycles");
                done = 1'b1;
            end
            next_cycle();
        end
    endtask

    task automatic d_txn(input logic [31:0] a, input logic w, input logic [N-1:0] wd,
                         input int gap, input int lat);
        for (int g = 0; g < gap; g++) begin
            bus.d_req   = 1'b0;
            bus.d_addr  = $urandom;
            bus.d_we    = 1'($urandom);
            bus.d_wdata = $urandom;
            next_cycle();
        end
        bus.d_req   = 1'b1;
        bus.d_addr  = a;
        bus.d_we    = w;
        bus.d_wdata = wd;
        push_exp(1'b1, a, w, wd, lat);
        wait_rv(1'b1);
        bus.d_req = 1'b0;
    endtask

    task automatic if_txn(input logic [31:0] a, input int gap, input int lat);
        for (int g = 0; g < gap; g++) begin
            bus.if_req  = 1'b0;
            bus.if_addr = $urandom;
            next_cycle();
        end
        bus.if_req  = 1'b1;
        bus.if_addr = a;
        push_exp(1'b0, a, 1'b0, '0, lat);
        wait_rv(1'b0);
        bus.if_req = 1'b0;
    endtask

    task automatic set_plan(input int r, input int v);
        plan_rand = 1'b0;
        plan_rdly = r;
        plan_vdly = v;
    endtask

    initial begin
        int t0;
        bit exp_g[$];
        bit last_d;
        bit w;

        rst         = 1'b1;
        bus.if_req  = 1'b0;
        bus.if_addr = '0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;
        preload(32'h100, 32'hDEAD_BEEF);
        repeat (3) next_cycle();
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_proc_req", bus.proc_req, 1'b0);
        chk("rst_we", bus.we, 1'b0);
        chk("rst_addr", bus.addr, 32'h0);
        chk("rst_wdata", bus.wdata, 32'h0);
        chk("rst_if_rvalid", bus.if_rvalid, 1'b0);
        chk("rst_d_rvalid", bus.d_rvalid, 1'b0);
        next_cycle();

        // Load: ready in cycle 1, valid in cycle 3
        set_plan(0, 2);
        iss_log.delete();
        dstall_log.delete();
        t0 = cyc;
        d_txn(32'h100, 1'b0, '0, 0, 3);
        chk("load_issue_beats", iss_log.size(), 1);
        if (iss_log.size() >= 1) chk("load_issue_cycle", iss_log[0].cyc - t0, 1);
        chk("load_stall_cycles", dstall_log.size(), 3);
        foreach (dstall_log[i]) chk("load_stall_cycle", dstall_log[i] - t0, i);

        // Store held in ISSUE for 5 cycles by mem_ready low
        set_plan(4, 1);
        iss_log.delete();
        t0 = cyc;
        d_txn(32'h40, 1'b1, 32'h1234_5678, 0, 6);
        chk("store_issue_beats", iss_log.size(), 5);
        foreach (iss_log[i]) begin
            chk("store_beat_cycle", iss_log[i].cyc - t0, i + 1);
            chk("store_beat_addr", iss_log[i].addr, 32'h40);
            chk("store_beat_we", iss_log[i].we, 1'b1);
            chk("store_beat_wdata", iss_log[i].wdata, 32'h1234_5678);
        end

        // Ready+valid together, back-to-back requests
        set_plan(0, 0);
        iss_log.delete();
        t0 = cyc;
        d_txn(32'h1000_0010, 1'b0, '0, 0, 1);
        d_txn(32'h1000_0014, 1'b0, '0, 0, 1);
        chk("b2b_issue_beats", iss_log.size(), 2);
        if (iss_log.size() >= 2) begin
            chk("b2b_first_issue", iss_log[0].cyc - t0, 1);
            chk("b2b_second_issue", iss_log[1].cyc - t0, 3);
        end

        // Reset while in WAIT, stray valid afterwards
        set_plan(0, 20);
        bus.d_req  = 1'b1;
        bus.d_addr = 32'h1000_0020;
        bus.d_we   = 1'b0;
        next_cycle();
        next_cycle();
        rst       = 1'b1;
        bus.d_req = 1'b0;
        next_cycle();
        rst = 1'b0;
        acc_q.delete();
        @(negedge clk);
        chk("wrst_proc_req", bus.proc_req, 1'b0);
        chk("wrst_addr", bus.addr, 32'h0);
        chk("wrst_we", bus.we, 1'b0);
        chk("wrst_wdata", bus.wdata, 32'h0);
        next_cycle();
        inj_valid = 1'b1;
        @(negedge clk);
        chk("wrst_valid_if_rvalid", bus.if_rvalid, 1'b0);
        chk("wrst_valid_d_rvalid", bus.d_rvalid, 1'b0);
        chk("wrst_valid_proc_req", bus.proc_req, 1'b0);
        next_cycle();
        inj_valid = 1'b0;
        @(negedge clk);
        chk("wrst_after_proc_req", bus.proc_req, 1'b0);
        next_cycle();

        // Valid while idle with no requests
        inj_valid = 1'b1;
        @(negedge clk);
        chk("idle_valid_if_rvalid", bus.if_rvalid, 1'b0);
        chk("idle_valid_d_rvalid", bus.d_rvalid, 1'b0);
        next_cycle();
        inj_valid = 1'b0;
        @(negedge clk);
        chk("idle_valid_proc_req", bus.proc_req, 1'b0);
        next_cycle();

        // Requester drops req after being latched; transaction still completes
        set_plan(1, 1);
        bus.d_req  = 1'b1;
        bus.d_addr = 32'h1000_0030;
        bus.d_we   = 1'b0;
        push_exp(1'b1, 32'h1000_0030, 1'b0, '0, 3);
        next_cycle();
        bus.d_req   = 1'b0;
        bus.d_addr  = 32'hFFFF_FFF0;
        bus.d_we    = 1'b1;
        bus.d_wdata = 32'hCAFE_F00D;
        wait_rv(1'b1);

        // Repeated ties from a fresh reset
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        plan_rand = 1'b1;
        grant_log.delete();
        for (int r = 0; r < 4; r++) begin
            fork
                if_txn(32'h0, 0, -1);
                d_txn(32'h200, 1'b0, '0, 0, -1);
            join
        end
        last_d = 1'b1;
        for (int r = 0; r < 4; r++) begin
`ifdef ARB_RR_EN
            w = !last_d;
`else
            w = 1'b1;
`endif
            exp_g.push_back(w);
            exp_g.push_back(!w);
            last_d = !w;
        end
        chk("tie_grants", grant_log.size(), 8);
        foreach (exp_g[i]) begin
            if (i < grant_log.size()) chk("tie_grant_is_d", grant_log[i], exp_g[i]);
        end

        // Randomized concurrent traffic from both ports
        fork
            begin
                for (int k = 0; k < 40; k++)
                    if_txn(32'($urandom_range(0, 15)) << 2, int'($urandom_range(0, 3)), -1);
            end
            begin
                for (int k = 0; k < 40; k++)
                    d_txn(32'h1000_0000 + (32'($urandom_range(0, 15)) << 2), 1'($urandom),
                          $urandom, int'($urandom_range(0, 3)), -1);
            end
        join

        repeat (5) next_cycle();
        chk("if_queue_drained", if_q.size(), 0);
        chk("d_queue_drained", d_q.size(), 0);
        chk("accept_queue_drained", acc_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish before time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter N, default 32, SHALL set data width; address width SHALL be fixed at 32.
REQ-002 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 if_req  in  1  instruction-fetch read request; if_addr  in  32  fetch address.
REQ-005 if_rvalid  out  1  fetch data valid pulse; if_rdata  out  N  fetch data; if_stall  out  1  fetch pending.
REQ-006 d_req  in  1  data request; d_we  in  1  1=store; d_addr  in  32; d_wdata  in  N.
REQ-007 d_rvalid  out  1  data completion pulse; d_rdata  out  N  load data; d_stall  out  1  data pending.
REQ-008 proc_req  out  1  memory request; we  out  1; addr  out  32; wdata  out  N.
REQ-009 mem_ready  in  1  memory accepts request; valid  in  1  response valid; rdata  in  N  response data.

Function
REQ-010 FSM SHALL have states IDLE, ISSUE, WAIT; at most one memory transaction SHALL be outstanding.
REQ-011 IDLE: if if_req or d_req, SHALL select a winner, latch its addr/we/wdata and owner into registers, go to ISSUE; else stay.
REQ-012 IF transactions SHALL always latch we=0 and wdata=0.
REQ-013 ISSUE: proc_req SHALL be 1; addr/we/wdata SHALL be driven from latched registers only; stay until mem_ready=1, then go to WAIT.
REQ-014 ISSUE with mem_ready=1 and valid=1 in the same cycle SHALL complete the transaction and go directly to IDLE.
REQ-015 WAIT: proc_req SHALL be 0; on valid=1, SHALL complete and go to IDLE.
REQ-016 Completion SHALL assert the owner's x_rvalid combinationally for exactly that cycle; if_rdata and d_rdata SHALL both equal rdata.
REQ-017 valid while in IDLE SHALL be ignored (no rvalid to either port).
REQ-018 x_stall SHALL equal x_req AND NOT x_rvalid.
REQ-019 Minimum latency: req sampled in cycle 0, proc_req in cycle 1, rvalid in cycle 1 at the earliest (ready+valid together).
REQ-020 After completion, the arbiter SHALL return to IDLE, so back-to-back transactions have exactly one IDLE cycle between them.
REQ-021 Requester SHALL hold req and its address/data stable until its rvalid; a req dropped after latching SHALL NOT abort the transaction.
REQ-022 Changes on the losing requester's inputs SHALL NOT affect the in-flight transaction.

Reset
REQ-023 On rst: state=IDLE; proc_req=0, we=0, addr=0, wdata=0; if_rvalid=0, d_rvalid=0; latched owner=DATA; last-served register=DATA.
REQ-024 rst mid-ISSUE/WAIT SHALL abandon the transaction; any later valid SHALL be ignored per REQ-017.

Configuration
REQ-025 Macro ARB_RR_EN undefined: on simultaneous if_req and d_req, data port SHALL win every time.
REQ-026 ARB_RR_EN defined: on simultaneous requests, the port not served last SHALL win; the last-served register SHALL update on every completion; after reset the first tie SHALL go to IF.
REQ-027 Single-requester behaviour SHALL be identical in both configurations.

Structure
REQ-028 Package mem_arb_pkg SHALL hold typedef arb_state_t {IDLE, ISSUE, WAIT} and owner_t {OWN_IF, OWN_D}.
REQ-029 Winner selection SHALL be a combinational sub-module mem_arb_pick (inputs if_req, d_req, last-served; output owner_t).

Verification
REQ-030 d_req=1, d_we=0, d_addr=0x100, memory ready in cycle 1 and valid with rdata=0xDEADBEEF in cycle 3 -> proc_req cycles 1; d_rvalid=1 with d_rdata=0xDEADBEEF in cycle 3 only; d_stall cycles 0-2.
REQ-031 if_req and d_req together (if_addr=0x0, d_addr=0x200), default build -> data served first, IF second; ARB_RR_EN build, repeated ties -> grants alternate IF, D, IF, D.
REQ-032 d_we=1, d_wdata=0x12345678, d_addr=0x40, mem_ready held low 4 cycles -> proc_req, we=1, addr=0x40, wdata=0x12345678 stable for all 5 ISSUE cycles.
REQ-033 ISSUE with mem_ready=1 and valid=1 same cycle -> rvalid pulse that cycle, IDLE next cycle, new request issued one cycle later.
REQ-034 rst in WAIT, then valid=1 two cycles later -> no rvalid on either port; proc_req=0.
REQ-035 valid=1 while in IDLE with no requests -> if_rvalid=0, d_rvalid=0; state stays IDLE.
